mem_ctrl: RTL

- Sequences the single byte-wide RAM/IO port and shares it between two requesters: instruction fetch and the load-store buffer (lsb).
- Serialises 1/2/4-byte loads and stores into byte beats, sign/zero-extends load results, and holds IO-space writes while the IO buffer is full.
- Drives the lsb handshake (is_io / mem_res_avail / mem_stuck) and a fetch handshake (if_req / if_ready).

---
 rtl/mem_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/mem_ctrl.sv
// Shares the byte-wide RAM/IO port between fetch and the lsb. Latency: n+2 cycles for loads and fetch, n+1 for stores.
// Backpressure: IO-space store beats wait while io_buffer_full is high; rdy_in low freezes everything.
module mem_ctrl #(
    parameter int         FETCH_BYTES = 4,
    parameter logic [1:0] IO_SEL      = 2'b11
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        rob_clear,
    input  logic        is_io,
    input  logic        is_store,
    input  logic [31:0] io_addr,
    input  logic [31:0] io_data,
    input  logic [2:0]  io_op,
    output logic        mem_res_avail,
    output logic [31:0] mem_res,
    output logic        mem_stuck,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_data,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_STORE = 3'd2;
    localparam logic [2:0] S_FETCH = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]  state;
    logic [2:0]  cnt;
    logic [2:0]  n_bytes;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic        uns_q;
    logic        fetch_q;
    logic        squash_q;
    logic [31:0] buf_q;
    logic [31:0] a_prev;

    logic        issuing;
    logic        io_stall;
    logic        done_ok;
    logic [1:0]  lane;
    logic        fill;
    logic [2:0]  req_n;
    logic [31:0] beat_addr;
    logic [31:0] dout_shift;
    logic [31:0] word_cap;
    logic [31:0] ext_word;

    assign beat_addr  = addr_q + {29'd0, cnt};
    assign issuing    = ((state == S_LOAD || state == S_FETCH) && cnt < n_bytes) || state == S_STORE;
    assign io_stall   = state == S_STORE && addr_q[17:16] == IO_SEL && io_buffer_full;
    assign dout_shift = data_q >> {cnt[1:0], 3'b000};

    // While frozen, repeat the last issued address so the byte arriving after
    // the freeze still belongs to the beat counter's idea of "previous beat".
    assign mem_a    = rdy_in ? (issuing ? beat_addr : 32'd0) : a_prev;
    assign mem_wr   = rdy_in && state == S_STORE && !io_stall;
    assign mem_dout = (state == S_STORE) ? dout_shift[7:0] : 8'd0;

    assign mem_stuck     = state != S_IDLE;
    assign done_ok       = state == S_DONE && rdy_in && !squash_q && !rob_clear;
    assign mem_res_avail = done_ok && !fetch_q;
    assign if_ready      = done_ok && fetch_q;

    always_comb begin
        case (io_op[1:0])
            2'd0:    req_n = 3'd1;
            2'd1:    req_n = 3'd2;
            default: req_n = 3'd4;
        endcase
    end

    // Merge the byte on mem_din now so the last byte lands without an extra cycle.
    always_comb begin
        lane     = cnt[1:0] - 2'd1;
        word_cap = buf_q;
        case (lane)
            2'd0:    word_cap[7:0]   = mem_din;
            2'd1:    word_cap[15:8]  = mem_din;
            2'd2:    word_cap[23:16] = mem_din;
            default: word_cap[31:24] = mem_din;
        endcase
    end

    always_comb begin
        ext_word = word_cap;
        fill     = 1'b0;
        case (n_bytes)
            3'd1: begin
                fill           = word_cap[7] & ~uns_q;
                ext_word[31:8] = {24{fill}};
            end
            3'd2: begin
                fill            = word_cap[15] & ~uns_q;
                ext_word[31:16] = {16{fill}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state    <= S_IDLE;
            cnt      <= 3'd0;
            n_bytes  <= 3'd0;
            addr_q   <= 32'd0;
            data_q   <= 32'd0;
            uns_q    <= 1'b0;
            fetch_q  <= 1'b0;
            squash_q <= 1'b0;
            buf_q    <= 32'd0;
            a_prev   <= 32'd0;
            mem_res  <= 32'd0;
            if_data  <= 32'd0;
        end else if (rdy_in) begin
            a_prev <= mem_a;
            case (state)
                S_IDLE: begin
                    cnt      <= 3'd0;
                    buf_q    <= 32'd0;
                    squash_q <= 1'b0;
                    if (!rob_clear && is_io) begin
                        addr_q  <= io_addr;
                        data_q  <= io_data;
                        uns_q   <= io_op[2];
                        n_bytes <= req_n;
                        fetch_q <= 1'b0;
                        state   <= is_store ? S_STORE : S_LOAD;
                    end else if (!rob_clear && if_req) begin
                        addr_q  <= if_addr;
                        uns_q   <= 1'b0;
                        n_bytes <= 3'(FETCH_BYTES);
                        fetch_q <= 1'b1;
                        state   <= S_FETCH;
                    end
                end
                S_LOAD, S_FETCH: begin
                    if (rob_clear) begin
                        state <= S_IDLE;
                    end else begin
                        if (cnt != 3'd0) buf_q <= word_cap;
                        if (cnt == n_bytes) begin
                            if (fetch_q) if_data <= word_cap;
                            else         mem_res <= ext_word;
                            state <= S_DONE;
                        end else begin
                            cnt <= cnt + 3'd1;
                        end
                    end
                end
                S_STORE: begin
                    // A flushed store is already committed: finish the beats, drop the pulse.
                    if (rob_clear) squash_q <= 1'b1;
                    if (!io_stall) begin
                        if (cnt == n_bytes - 3'd1) begin
                            mem_res <= 32'd0;
                            state   <= S_DONE;
                        end else begin
                            cnt <= cnt + 3'd1;
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
